// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
// State encoding and requester count.
package ram_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
// master drives requests, slave (the arbiter) answers.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);

    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
    logic [NUM_REQ-1:0]            o_ack;
    logic                          o_err;
    logic [DATA_WIDTH-1:0]         o_rdata;
    logic                          o_busy;

    modport master (
        output i_req,
        output i_we,
        output i_addr,
        output i_wdata,
        input  o_ack,
        input  o_err,
        input  o_rdata,
        input  o_busy
    );

    modport slave (
        input  i_req,
        input  i_we,
        input  i_addr,
        input  i_wdata,
        output o_ack,
        output o_err,
        output o_rdata,
        output o_busy
    );

endinterface

// File: rtl/ram_arbiter_rr_grant.sv
// Two-way round-robin picker.
// On a tie the requester not served last wins.
module rr_grant
    import ram_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               grant_id,
    output logic               grant_valid
);

    assign grant_valid = |req;

    // Pick the winner: alternate on ties, otherwise the lone requester.
    always_comb begin
        grant_id = 1'b0;
        unique case (1'b1)
            (req == 2'b11):        grant_id = ~last;
            (req == 2'b10):        grant_id = 1'b1;
            default:               grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters.
// Serialises requests into one-cycle strobes with a done timeout.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    ram_arbiter_if.slave          bus,
    output logic                  o_ram_read,
    output logic                  o_ram_write,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic                  i_ram_done,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t                state;
    logic                  last;
    logic                  lat_id;
    logic                  lat_we;
    logic                  grant_id;
    logic                  grant_valid;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;

    rr_grant u_grant (
        .req         (bus.i_req),
        .last        (last),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign sel_we    = bus.i_we[grant_id];
    assign sel_addr  = bus.i_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = bus.i_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];

    // Saturating increment so a long stall can never wrap the counter.
    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Main FSM: arbitrate, strobe, wait for done or timeout, acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            last          <= 1'b1;
            lat_id        <= 1'b0;
            lat_we        <= 1'b0;
            cnt           <= '0;
            o_ram_read    <= 1'b0;
            o_ram_write   <= 1'b0;
            o_ram_address <= '0;
            o_ram_data    <= '0;
            bus.o_ack     <= '0;
            bus.o_err     <= 1'b0;
            bus.o_rdata   <= '0;
            bus.o_busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id        <= grant_id;
                        lat_we        <= sel_we;
                        o_ram_address <= sel_addr;
                        o_ram_data    <= sel_we ? sel_wdata : '0;
                        o_ram_write   <= sel_we;
                        o_ram_read    <= ~sel_we;
                        bus.o_busy    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_ram_read  <= 1'b0;
                    o_ram_write <= 1'b0;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (i_ram_done) begin
                        if (!lat_we) begin
                            bus.o_rdata <= i_ram_data;
                        end
                        bus.o_err         <= 1'b0;
                        bus.o_ack[lat_id] <= 1'b1;
                        state             <= ACK;
                    end else if (cnt_next == CNT_MAX) begin
                        bus.o_err         <= 1'b1;
                        bus.o_rdata       <= '0;
                        bus.o_ack[lat_id] <= 1'b1;
                        state             <= ACK;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ACK: begin
                    bus.o_ack  <= '0;
                    bus.o_busy <= 1'b0;
                    last       <= lat_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle RAM model.
// Expected values are hand-derived cycle by cycle.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          ram_rd;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q = '0;
    logic          ram_done;
    logic          model_done = 1'b0;
    logic          stray_done;

    assign ram_done = model_done | stray_done;

    ram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .bus           (bus),
        .o_ram_read    (ram_rd),
        .o_ram_write   (ram_wr),
        .o_ram_address (ram_addr),
        .o_ram_data    (ram_wdata),
        .i_ram_done    (ram_done),
        .i_ram_data    (ram_q)
    );

    // RAM model: done and read data one cycle after a strobe.
    logic [DW-1:0] mem [16];
    bit            ram_en;
    bit            ovr_en;
    logic [DW-1:0] ovr_data;

    always @(posedge clk) begin
        model_done <= ram_en && (ram_rd || ram_wr);
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_q <= ovr_en ? ovr_data : mem[ram_addr];
    end

    // Strobe monitor: counts strobe cycles and back-to-back strobes.
    bit mon_en;
    int strobe_cnt = 0;
    int dbl_cnt    = 0;
    bit prev_strb  = 1'b0;

    always @(posedge clk) begin
        if (mon_en) begin
            if (ram_rd || ram_wr) strobe_cnt <= strobe_cnt + 1;
            if ((ram_rd || ram_wr) && prev_strb) dbl_cnt <= dbl_cnt + 1;
            prev_strb <= ram_rd || ram_wr;
        end
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.i_req[k]           = 1'b1;
        bus.i_we[k]            = we;
        bus.i_addr[k*AW +: AW] = a;
        bus.i_wdata[k*DW +: DW] = d;
    endtask

    task automatic clr_req(int k);
        bus.i_req[k] = 1'b0;
    endtask

    task automatic wait_ack(output int id, output int cyc);
        id  = -1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (bus.o_ack != 2'b00) begin
                id = bus.o_ack[1] ? 1 : 0;
                return;
            end
        end
        chk("ack_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int id;
    int prev_id;
    int cyc;
    bit early;

    initial begin
        rst         = 1'b1;
        bus.i_req   = '0;
        bus.i_we    = '0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        stray_done  = 1'b0;
        ram_en      = 1'b1;
        ovr_en      = 1'b0;
        ovr_data    = '0;
        mon_en      = 1'b0;
        tick();
        tick();
        chk("reset_outs",
            {bus.o_ack, bus.o_err, bus.o_rdata, bus.o_busy,
             ram_rd, ram_wr, ram_addr, ram_wdata}, 32'd0);
        rst = 1'b0;
        tick();

        // Write by requester 0
        set_req(0, 1'b1, 4'd3, 8'hA5);
        tick();
        chk("wr_c1_strobes", {ram_wr, ram_rd, bus.o_busy}, 3'b101);
        chk("wr_c1_addr", ram_addr, 4'd3);
        chk("wr_c1_data", ram_wdata, 8'hA5);
        tick();
        chk("wr_c2_strobe_done", {ram_wr, ram_rd, ram_done}, 3'b001);
        chk("wr_c2_noack", bus.o_ack, 2'b00);
        tick();
        chk("wr_c3_ack_err", {bus.o_ack, bus.o_err}, 3'b010);
        clr_req(0);
        tick();
        chk("wr_c4_idle", {bus.o_ack, bus.o_busy}, 3'b000);
        chk("wr_mem", mem[3], 8'hA5);

        // Read by requester 1
        ovr_en   = 1'b1;
        ovr_data = 8'h5A;
        set_req(1, 1'b0, 4'd3, 8'hFF);
        tick();
        chk("rd_c1_strobes", {ram_wr, ram_rd}, 2'b01);
        chk("rd_c1_addr_data", {ram_addr, ram_wdata}, {4'd3, 8'h00});
        tick();
        chk("rd_c2_strobe", {ram_wr, ram_rd}, 2'b00);
        tick();
        chk("rd_c3_ack", {bus.o_ack, bus.o_err}, 3'b100);
        chk("rd_c3_rdata", bus.o_rdata, 8'h5A);
        clr_req(1);
        tick();

        // Continuous tie after reset: 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ovr_data = 8'h3C;
        mon_en   = 1'b1;
        set_req(0, 1'b0, 4'd1, 8'h00);
        set_req(1, 1'b0, 4'd2, 8'h00);
        prev_id = -1;
        for (int t = 0; t < 4; t++) begin
            wait_ack(id, cyc);
            chk($sformatf("rr_order%0d", t), id, t % 2);
            chk($sformatf("rr_spacing%0d", t), cyc, (t == 0) ? 3 : 4);
            chk($sformatf("rr_no_repeat%0d", t), id == prev_id, 1'b0);
            prev_id = id;
        end
        chk("rr_rdata", bus.o_rdata, 8'h3C);
        clr_req(0);
        clr_req(1);
        tick();
        tick();
        mon_en = 1'b0;
        chk("rr_strobe_cnt", strobe_cnt, 4);
        chk("rr_strobe_width", dbl_cnt, 0);

        // Timeout: RAM never answers
        ram_en = 1'b0;
        set_req(0, 1'b0, 4'd7, 8'h00);
        early = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.o_ack != 2'b00) early = 1'b1;
        end
        chk("tmo_no_early_ack", early, 1'b0);
        tick();
        chk("tmo_c17_ack_err", {bus.o_ack, bus.o_err}, 3'b011);
        chk("tmo_c17_rdata", bus.o_rdata, 8'h00);
        clr_req(0);
        ram_en = 1'b1;
        tick();
        ovr_data = 8'hC3;
        set_req(0, 1'b0, 4'd5, 8'h00);
        wait_ack(id, cyc);
        chk("post_tmo_id", id, 0);
        chk("post_tmo_lat", cyc, 3);
        chk("post_tmo_err_rdata", {bus.o_err, bus.o_rdata}, {1'b0, 8'hC3});
        clr_req(0);
        tick();

        // Reset while waiting: no ack, last reset to 1
        set_req(0, 1'b1, 4'd9, 8'h11);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_outs",
            {bus.o_ack, bus.o_err, bus.o_rdata, bus.o_busy,
             ram_rd, ram_wr, ram_addr, ram_wdata}, 32'd0);
        rst = 1'b0;
        clr_req(0);
        tick();
        chk("rst_wait_noack", bus.o_ack, 2'b00);
        set_req(0, 1'b0, 4'd1, 8'h00);
        set_req(1, 1'b0, 4'd2, 8'h00);
        wait_ack(id, cyc);
        chk("rst_tie_winner", id, 0);
        clr_req(0);
        clr_req(1);
        tick();
        tick();

        // Stray done in IDLE and ISSUE
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_idle", {bus.o_ack, bus.o_busy}, 3'b000);
        tick();
        chk("stray_idle_after", {bus.o_ack, bus.o_busy}, 3'b000);
        ram_en   = 1'b0;
        ovr_data = 8'h77;
        set_req(0, 1'b0, 4'd4, 8'h00);
        wait_ack(id, cyc);
        clr_req(0);
        tick();
        chk("stray_pre_rdata", bus.o_rdata, 8'h00);
        set_req(1, 1'b1, 4'd2, 8'h66);
        tick();
        stray_done = 1'b1;
        tick();
        chk("stray_issue_noack", {bus.o_ack, bus.o_busy}, 3'b001);
        tick();
        stray_done = 1'b0;
        chk("wait_done_ack", {bus.o_ack, bus.o_err}, 3'b100);
        clr_req(1);
        tick();
        chk("wr_rdata_kept", {bus.o_busy, bus.o_rdata}, {1'b0, 8'h00});
        ram_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter that shares one single-port synchronous RAM (one-cycle `o_done` response) between two masters, e.g. a CPU port and a DMA port. It accepts `req`/`ack` transactions and serialises them into single-cycle RAM read/write strobes. It waits for the RAM done pulse and returns read data and completion, or an error on timeout, to the winning requester. It sits directly in front of the RAM and is the only block that drives the RAM's control inputs.

## Interface
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 4, RAM address width
- `TIMEOUT`, 15, maximum cycles spent in WAIT before aborting (must be ≥1)

- `i_clk`  in  1  single clock, all logic on posedge
- `i_reset`  in  1  synchronous, active-high reset
- `i_req`  in  2  bit k: requester k has a pending access
- `i_we`  in  2  bit k: 1 = write, 0 = read
- `i_addr`  in  2*ADDR_WIDTH  slice k = `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `i_wdata`  in  2*DATA_WIDTH  slice k, write data
- `o_ack`  out  2  one-cycle completion pulse to requester k
- `o_err`  out  1  valid with `o_ack`; 1 = timed out
- `o_rdata`  out  DATA_WIDTH  read data, valid with `o_ack`
- `o_busy`  out  1  high in every state except IDLE
- `o_ram_read`, `o_ram_write`  out  1  RAM strobes
- `o_ram_address`  out  ADDR_WIDTH  RAM address
- `o_ram_data`  out  DATA_WIDTH  RAM write data
- `i_ram_done`  in  1  RAM completion pulse
- `i_ram_data`  in  DATA_WIDTH  RAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE:**
  - If any `i_req` is high, pick a winner and latch its `we`/`addr`/`wdata` and id, then go to ISSUE.
  - If both requests are high, the winner is the requester not served last (`last` register).
  - If one request is high, that requester wins regardless of `last`.
- **ISSUE (1 cycle):**
  - Drive `o_ram_write` = latched we, or `o_ram_read` = !we. Exactly one strobe is high, for exactly one cycle.
  - Drive address and data from the latch.
  - Clear the timeout counter, then go to WAIT.
- **WAIT:**
  - Strobes are low. Address and data stay held.
  - On `i_ram_done`: for reads, register `o_rdata` ← `i_ram_data`; for writes, leave `o_rdata` unchanged. Set `o_err`=0 and go to ACK.
  - If the counter reaches TIMEOUT without done: set `o_err`=1, set `o_rdata`=0, go to ACK.
  - Counter width is `$clog2(TIMEOUT+1)` and it saturates, never wraps.
- **ACK (1 cycle):** `o_ack[id]`=1, `last` ← id, go to IDLE.
- **Requester rule:** hold `req` and operands stable until `ack`, then drop `req` in the cycle after `ack` (or hold it for a back-to-back access).
- `i_ram_done` outside WAIT is ignored.
- `o_rdata` and `o_err` hold their values between acks.
- `o_ram_data` is 0 during reads.

## Timing
- **Reset:** state IDLE. `o_ack`, `o_err`, `o_rdata`, `o_busy`, strobes, `o_ram_address` and `o_ram_data` are all 0. `last`=1, so requester 0 wins the first tie.
- **Reset mid-transaction:** the transaction is abandoned with no ack. Strobes are low in the cycle after reset is sampled.
- **Nominal latency:**
  - Cycle 0: `req` seen in IDLE.
  - Cycle 1: strobe.
  - Cycle 2: RAM done.
  - Cycle 3: `o_ack`.
  - Cycle 4: IDLE, arbitration resumes.
- Throughput is one access per 4 cycles.
- **Timeout latency:** ack in cycle TIMEOUT+2.
- Arbitration happens only in IDLE. A request arriving mid-transaction waits. The `req` of the other requester may remain high indefinitely.
- `o_busy` is high in cycles 1–3.

## Structure
- `ram_arbiter_pkg`: `state_t` enum (IDLE/ISSUE/WAIT/ACK) and `NUM_REQ`=2.
- Sub-module `rr_grant`: combinational 2-way round-robin picker (`req[1:0]`, `last` → `grant_id`, `grant_valid`).
- FSM, latches and timeout counter live in `ram_arbiter`.

## Test plan
- Reset, then req0 write addr 3 data 0xA5: `o_ram_write` high cycle 1, addr 3 data 0xA5. RAM done cycle 2 gives `o_ack[0]` cycle 3 with `o_err`=0.
- req1 read addr 3 with RAM model returning 0x5A: `o_ram_read` one cycle, `o_ack[1]`=1 with `o_rdata`=0x5A.
- Both req high continuously after reset: grant order 0,1,0,1. No requester acked twice in a row. Each strobe lasts one cycle.
- RAM never asserts done, TIMEOUT=15: `o_ack[k]`=1 with `o_err`=1 and `o_rdata`=0 in cycle 17. Next request proceeds normally.
- `i_reset` asserted in WAIT: no `o_ack`. All outputs 0 next cycle. A later tie is granted to requester 0.
- Stray `i_ram_done` in IDLE and ISSUE: no state change and no ack.
